// File: rtl/traffic_seq_monitor_pkg.sv
// Shared types for the traffic light controller and its sequence monitor.
//   light_t      : light color encoding (2'b11 is not a legal color)
//   mon_err_t    : monitor error codes, ordered by reporting priority
//   trk_state_t  : round tracker states
//   next_color() : legal successor of a color (RED->GREEN->YELLOW->RED)
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } light_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ENC   = 2'd1,
    ERR_SKIP  = 2'd2,
    ERR_STUCK = 2'd3
  } mon_err_t;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_R    = 2'd1,
    S_G    = 2'd2,
    S_Y    = 2'd3
  } trk_state_t;

  // The illegal encoding maps to RED so that a RED sample right after it
  // is treated as a fresh start rather than a second error.
  function automatic light_t next_color(input light_t c);
    case (c)
      RED:     return GREEN;
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_seq_monitor_if.sv
// Monitor signal bundle.
//   master : drives color / mon_en / clr_err, observes status
//   slave  : the monitor; observes color, drives err / err_code / seq_ok /
//            cycle_cnt / err_cnt
interface traffic_seq_monitor_if
  import traffic_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  light_t             color;
  logic               mon_en;
  logic               clr_err;
  logic               err;
  mon_err_t           err_code;
  logic               seq_ok;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [7:0]         err_cnt;

  modport master (
    output color, mon_en, clr_err,
    input  err, err_code, seq_ok, cycle_cnt, err_cnt
  );

  modport slave (
    input  color, mon_en, clr_err,
    output err, err_code, seq_ok, cycle_cnt, err_cnt
  );

endinterface

// File: rtl/traffic_seq_monitor_tracker.sv
// Round tracker: follows RED->GREEN->YELLOW->RED and counts completed rounds.
//   clk, rst_n : clock, async active-low reset
//   sample     : a color is sampled this edge
//   color      : sampled color
//   sync_clr   : error on this sample or monitor disabled; back to S_SYNC
//   cycle_cnt  : completed rounds, saturating
//   seq_ok     : one-cycle pulse per completed round
//
// state  | meaning
// S_SYNC | waiting for a RED to align to the sequence
// S_R    | in red phase
// S_G    | in green phase
// S_Y    | in yellow phase; next RED completes a round
module traffic_seq_tracker
  import traffic_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample,
  input  light_t           color,
  input  logic             sync_clr,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             seq_ok
);

  trk_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_SYNC;
      cycle_cnt <= '0;
      seq_ok    <= 1'b0;
    end else begin
      seq_ok <= 1'b0;
      // an offending sample is never used to resync, even if it is RED
      if (sync_clr) begin
        state <= S_SYNC;
      end else if (sample) begin
        case (state)
          S_SYNC: if (color == RED)    state <= S_R;
          S_R:    if (color == GREEN)  state <= S_G;
          S_G:    if (color == YELLOW) state <= S_Y;
          S_Y: begin
            if (color == RED) begin
              state  <= S_R;
              seq_ok <= 1'b1;
              if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

endmodule

// File: rtl/traffic_seq_monitor.sv
// Sequence checker for the traffic light controller's color output.
// Flags illegal encodings, skipped phases and stuck phases; counts rounds.
//   clk, rst_n : clock, async active-low reset
//   mon        : traffic_seq_monitor_if.slave (color/mon_en/clr_err in,
//                err/err_code/seq_ok/cycle_cnt/err_cnt out)
// Build option: TRAFFIC_MON_STATS_EN builds the saturating error-event
// counter; without it err_cnt reads 0.
module traffic_seq_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int STUCK_LIMIT = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  traffic_seq_monitor_if.slave  mon
);

  localparam int DW = $clog2(STUCK_LIMIT + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(STUCK_LIMIT);

  light_t          prev_color;
  logic            prev_valid;
  logic [DW-1:0]   dwell;
  logic            err_q;
  mon_err_t        err_code_q;

  logic            sample;
  logic            same;
  logic            enc_hit, skip_hit, stuck_hit, err_hit;
  mon_err_t        hit_code;

  always_comb begin
    sample    = mon.mon_en;
    same      = prev_valid && (mon.color == prev_color);
    enc_hit   = sample && (2'(mon.color) == 2'b11);
    skip_hit  = sample && prev_valid && !same && (mon.color != next_color(prev_color));
    // fires only on the repeat that brings dwell up to the limit; dwell then holds
    stuck_hit = sample && same && (dwell == DWELL_MAX - DW'(1));
    err_hit   = enc_hit || skip_hit || stuck_hit;
    hit_code  = ERR_NONE;
    if (enc_hit)        hit_code = ERR_ENC;
    else if (skip_hit)  hit_code = ERR_SKIP;
    else if (stuck_hit) hit_code = ERR_STUCK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_color <= RED;
      prev_valid <= 1'b0;
      dwell      <= '0;
    end else if (!sample) begin
      prev_valid <= 1'b0;
      dwell      <= '0;
    end else begin
      prev_color <= mon.color;
      prev_valid <= 1'b1;
      if (!same)                  dwell <= '0;
      else if (dwell != DWELL_MAX) dwell <= dwell + DW'(1);
    end
  end

  // A new error beats a simultaneous clear and reports its own code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (err_hit) begin
      err_q <= 1'b1;
      if (!err_q || mon.clr_err) err_code_q <= hit_code;
    end else if (mon.clr_err) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end
  end

  assign mon.err      = err_q;
  assign mon.err_code = err_code_q;

`ifdef TRAFFIC_MON_STATS_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (mon.clr_err) begin
      err_cnt_q <= err_hit ? 8'd1 : 8'd0;
    end else if (err_hit && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign mon.err_cnt = err_cnt_q;
`else
  assign mon.err_cnt = 8'd0;
`endif

  traffic_seq_tracker #(.CNT_W(CNT_W)) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (sample),
    .color     (mon.color),
    .sync_clr  (err_hit || !sample),
    .cycle_cnt (mon.cycle_cnt),
    .seq_ok    (mon.seq_ok)
  );

endmodule

// File: tb/tb_traffic_seq_monitor.sv
// Directed bench for traffic_seq_monitor.
module tb_traffic_seq_monitor;
  import traffic_pkg::*;

`ifdef TRAFFIC_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  traffic_seq_monitor_if #(.CNT_W(16)) tif ();

  traffic_seq_monitor #(.CNT_W(16), .STUCK_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (tif.slave)
  );

  always #5 clk = ~clk;

  // present one sample, let the edge take it, look 1 ns later
  task automatic smp(input logic [1:0] c, input logic en, input logic clr);
    tif.color   = light_t'(c);
    tif.mon_en  = en;
    tif.clr_err = clr;
    @(posedge clk);
    #1;
    tif.clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    tif.mon_en  = 1'b0;
    tif.clr_err = 1'b0;
    tif.color   = RED;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tif.err !== 1'b0) begin errors++; $display("FAIL reset_err got %0d exp 0", tif.err); end
    checks++; if (tif.err_code !== ERR_NONE) begin errors++; $display("FAIL reset_code got %0d exp 0", tif.err_code); end
    checks++; if (tif.seq_ok !== 1'b0) begin errors++; $display("FAIL reset_seq_ok got %0d exp 0", tif.seq_ok); end
    checks++; if (tif.cycle_cnt !== 16'd0) begin errors++; $display("FAIL reset_cycle_cnt got %0d exp 0", tif.cycle_cnt); end
    checks++; if (tif.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", tif.err_cnt); end
  endtask

  task automatic test_rounds();
    logic [1:0] seq_c [9] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic       exp_ok [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      smp(seq_c[i], 1'b1, 1'b0);
      checks++;
      if (tif.seq_ok !== exp_ok[i]) begin
        errors++; $display("FAIL rounds_seq_ok[%0d] got %0d exp %0d", i, tif.seq_ok, exp_ok[i]);
      end
    end
    checks++; if (tif.cycle_cnt !== 16'd2) begin errors++; $display("FAIL rounds_cycle_cnt got %0d exp 2", tif.cycle_cnt); end
    checks++; if (tif.err !== 1'b0) begin errors++; $display("FAIL rounds_err got %0d exp 0", tif.err); end
  endtask

  task automatic test_skip();
    do_reset();
    smp(2'd0, 1'b1, 1'b0);
    smp(2'd1, 1'b1, 1'b0);
    checks++; if (tif.err !== 1'b0) begin errors++; $display("FAIL skip_pre_err got %0d exp 0", tif.err); end
    smp(2'd0, 1'b1, 1'b0);
    checks++; if (tif.err !== 1'b1) begin errors++; $display("FAIL skip_err got %0d exp 1", tif.err); end
    checks++; if (tif.err_code !== ERR_SKIP) begin errors++; $display("FAIL skip_code got %0d exp 2", tif.err_code); end
    smp(2'd0, 1'b1, 1'b0);
    smp(2'd1, 1'b1, 1'b0);
    smp(2'd2, 1'b1, 1'b0);
    checks++; if (tif.cycle_cnt !== 16'd0) begin errors++; $display("FAIL skip_cnt_before got %0d exp 0", tif.cycle_cnt); end
    smp(2'd0, 1'b1, 1'b0);
    checks++; if (tif.seq_ok !== 1'b1) begin errors++; $display("FAIL skip_seq_ok got %0d exp 1", tif.seq_ok); end
    checks++; if (tif.cycle_cnt !== 16'd1) begin errors++; $display("FAIL skip_cnt_after got %0d exp 1", tif.cycle_cnt); end
    checks++; if (tif.err_code !== ERR_SKIP) begin errors++; $display("FAIL skip_code_kept got %0d exp 2", tif.err_code); end
  endtask

  task automatic test_enc();
    do_reset();
    smp(2'd3, 1'b1, 1'b0);
    checks++; if (tif.err !== 1'b1) begin errors++; $display("FAIL enc_err got %0d exp 1", tif.err); end
    checks++; if (tif.err_code !== ERR_ENC) begin errors++; $display("FAIL enc_code got %0d exp 1", tif.err_code); end
    smp(2'd0, 1'b1, 1'b0);
    checks++; if (tif.err_cnt !== (STATS ? 8'd1 : 8'd0)) begin errors++; $display("FAIL enc_err_cnt1 got %0d exp %0d", tif.err_cnt, STATS ? 1 : 0); end
    smp(2'd2, 1'b1, 1'b0);
    checks++; if (tif.err_code !== ERR_ENC) begin errors++; $display("FAIL enc_code_kept got %0d exp 1", tif.err_code); end
    checks++; if (tif.err_cnt !== (STATS ? 8'd2 : 8'd0)) begin errors++; $display("FAIL enc_err_cnt2 got %0d exp %0d", tif.err_cnt, STATS ? 2 : 0); end
  endtask

  task automatic test_stuck();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      smp(2'd1, 1'b1, 1'b0);
      checks++;
      if (tif.err !== 1'b0) begin errors++; $display("FAIL stuck_early[%0d] got %0d exp 0", i, tif.err); end
    end
    smp(2'd1, 1'b1, 1'b0);
    checks++; if (tif.err !== 1'b1) begin errors++; $display("FAIL stuck_err got %0d exp 1", tif.err); end
    checks++; if (tif.err_code !== ERR_STUCK) begin errors++; $display("FAIL stuck_code got %0d exp 3", tif.err_code); end
  endtask

  task automatic test_clr_collision();
    do_reset();
    smp(2'd3, 1'b1, 1'b0);
    smp(2'd0, 1'b1, 1'b0);
    smp(2'd1, 1'b1, 1'b0);
    smp(2'd2, 1'b1, 1'b0);
    smp(2'd1, 1'b1, 1'b1);
    checks++; if (tif.err !== 1'b1) begin errors++; $display("FAIL clr_hit_err got %0d exp 1", tif.err); end
    checks++; if (tif.err_code !== ERR_SKIP) begin errors++; $display("FAIL clr_hit_code got %0d exp 2", tif.err_code); end
    checks++; if (tif.err_cnt !== (STATS ? 8'd1 : 8'd0)) begin errors++; $display("FAIL clr_hit_err_cnt got %0d exp %0d", tif.err_cnt, STATS ? 1 : 0); end
    smp(2'd1, 1'b1, 1'b1);
    checks++; if (tif.err !== 1'b0) begin errors++; $display("FAIL clr_err got %0d exp 0", tif.err); end
    checks++; if (tif.err_code !== ERR_NONE) begin errors++; $display("FAIL clr_code got %0d exp 0", tif.err_code); end
    checks++; if (tif.err_cnt !== 8'd0) begin errors++; $display("FAIL clr_err_cnt got %0d exp 0", tif.err_cnt); end
  endtask

  task automatic test_mon_en_and_reset();
    do_reset();
    smp(2'd0, 1'b1, 1'b0);
    smp(2'd1, 1'b1, 1'b0);
    smp(2'd1, 1'b0, 1'b0);
    smp(2'd1, 1'b0, 1'b0);
    smp(2'd2, 1'b1, 1'b0);
    smp(2'd0, 1'b1, 1'b0);
    checks++; if (tif.err !== 1'b0) begin errors++; $display("FAIL en_err got %0d exp 0", tif.err); end
    checks++; if (tif.seq_ok !== 1'b0) begin errors++; $display("FAIL en_seq_ok got %0d exp 0", tif.seq_ok); end
    checks++; if (tif.cycle_cnt !== 16'd0) begin errors++; $display("FAIL en_cnt got %0d exp 0", tif.cycle_cnt); end
    smp(2'd1, 1'b1, 1'b0);
    smp(2'd2, 1'b1, 1'b0);
    smp(2'd0, 1'b1, 1'b0);
    checks++; if (tif.cycle_cnt !== 16'd1) begin errors++; $display("FAIL en_resync_cnt got %0d exp 1", tif.cycle_cnt); end
    smp(2'd3, 1'b1, 1'b0);
    checks++; if (tif.err !== 1'b1) begin errors++; $display("FAIL pre_rst_err got %0d exp 1", tif.err); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (tif.err !== 1'b0) begin errors++; $display("FAIL async_rst_err got %0d exp 0", tif.err); end
    checks++; if (tif.err_code !== ERR_NONE) begin errors++; $display("FAIL async_rst_code got %0d exp 0", tif.err_code); end
    checks++; if (tif.cycle_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_cnt got %0d exp 0", tif.cycle_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tif.color   = RED;
    tif.mon_en  = 1'b0;
    tif.clr_err = 1'b0;
    test_reset();
    test_rounds();
    test_skip();
    test_enc();
    test_stuck();
    test_clr_collision();
    test_mon_en_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
